// File: rtl/clk_ratio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_ratio_pkg
//  Description : Shared definitions for the clock-ratio monitor. Holds the
//                monitor state encoding and the default width constants.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_ratio_pkg;

    localparam int unsigned c_DEF_RATIO_WIDTH = 4;
    localparam int unsigned c_DEF_CNT_WIDTH   = c_DEF_RATIO_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_e;

endpackage : clk_ratio_pkg
`default_nettype wire

// File: rtl/clk_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : clk_edge_det
//  Description : Two-stage sampler for a divided clock treated as data, with
//                rising-edge detection on the sampled value.
//  Ports       : i_clk   - reference clock (rising edge)
//                i_rst_n - asynchronous active-low reset
//                i_d     - divided clock under test
//                o_s1    - first sampled stage (level of the divided clock)
//                o_rise  - one-cycle pulse when the sampled level goes 0->1
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_s1,
    output logic o_rise
);

    logic r_s1_q;
    logic r_s2_q;
    logic w_s1_d;
    logic w_s2_d;

    always_comb begin
        w_s1_d = i_d;
        w_s2_d = r_s1_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_q <= 1'b0;
            r_s2_q <= 1'b0;
        end else begin
            r_s1_q <= w_s1_d;
            r_s2_q <= w_s2_d;
        end
    end

    assign o_s1   = r_s1_q;
    assign o_rise = r_s1_q & ~r_s2_q;

endmodule : clk_edge_det
`default_nettype wire

// File: rtl/clk_ratio_mon.sv
`default_nettype none
// ============================================================================
//  Module      : clk_ratio_mon
//  Description : Measures the period and high time of a divided clock in
//                reference-clock cycles, compares against an expected ratio
//                and flags a stuck (edgeless) divided clock.
//  Ports       : i_ref_clk   - reference clock (rising edge)
//                i_rst_n     - asynchronous active-low reset
//                i_en        - monitor enable
//                i_div_clk   - divided clock under test (sampled as data)
//                i_exp_ratio - expected division ratio
//                o_period    - last measured period
//                o_high      - last measured high time
//                o_valid     - one-cycle pulse when o_period/o_high update
//                o_match     - last measurement matched the expected ratio
//                o_stuck     - sticky: no rising edge within the timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_ratio_mon
    import clk_ratio_pkg::*;
#(
    parameter int unsigned DIV_RATIO_WIDTH = c_DEF_RATIO_WIDTH,
    parameter int unsigned CNT_WIDTH       = DIV_RATIO_WIDTH + 1
) (
    input  logic                       i_ref_clk,
    input  logic                       i_rst_n,
    input  logic                       i_en,
    input  logic                       i_div_clk,
    input  logic [DIV_RATIO_WIDTH-1:0] i_exp_ratio,
    output logic [CNT_WIDTH-1:0]       o_period,
    output logic [CNT_WIDTH-1:0]       o_high,
    output logic                       o_valid,
    output logic                       o_match,
    output logic                       o_stuck
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    state_e               r_state_q,    w_state_d;
    logic [CNT_WIDTH-1:0] r_per_cnt_q,  w_per_cnt_d;
    logic [CNT_WIDTH-1:0] r_high_cnt_q, w_high_cnt_d;
    logic [CNT_WIDTH-1:0] r_period_q,   w_period_d;
    logic [CNT_WIDTH-1:0] r_high_q,     w_high_d;
    logic                 r_valid_q,    w_valid_d;
    logic                 r_match_q,    w_match_d;
    logic                 r_stuck_q,    w_stuck_d;

    logic                 w_s1;
    logic                 w_rise;
    logic [CNT_WIDTH-1:0] w_exp_ext;
    logic [CNT_WIDTH-1:0] w_half_lo;
    logic [CNT_WIDTH-1:0] w_half_hi;
    logic                 w_match;
    logic [CNT_WIDTH-1:0] w_per_inc;
    logic [CNT_WIDTH-1:0] w_high_inc;

    clk_edge_det u_edge_det (
        .i_clk   (i_ref_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_div_clk),
        .o_s1    (w_s1),
        .o_rise  (w_rise)
    );

    // Ratio check uses the expected value present in the edge cycle. An odd
    // ratio allows either rounding of the half period for the high time.
    // Ratios 0 and 1 cannot be resolved by sampling, so they never match.
    always_comb begin
        w_exp_ext = CNT_WIDTH'(i_exp_ratio);
        w_half_lo = w_exp_ext >> 1;
        w_half_hi = (w_exp_ext + c_CNT_ONE) >> 1;
        w_match   = (w_exp_ext[CNT_WIDTH-1:1] != '0)
                 && (r_per_cnt_q == w_exp_ext)
                 && ((r_high_cnt_q == w_half_lo) || (r_high_cnt_q == w_half_hi));
    end

    // Saturating increments: counters never wrap to zero.
    always_comb begin
        w_per_inc  = (r_per_cnt_q  == c_CNT_MAX) ? r_per_cnt_q  : r_per_cnt_q  + c_CNT_ONE;
        w_high_inc = (r_high_cnt_q == c_CNT_MAX) ? r_high_cnt_q : r_high_cnt_q + c_CNT_ONE;
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_per_cnt_d  = r_per_cnt_q;
        w_high_cnt_d = r_high_cnt_q;
        w_period_d   = r_period_q;
        w_high_d     = r_high_q;
        w_valid_d    = 1'b0;
        w_match_d    = r_match_q;
        w_stuck_d    = r_stuck_q;

        if (!i_en) begin
            // Results hold; the stuck flag is dropped on disable.
            w_state_d    = ST_IDLE;
            w_per_cnt_d  = '0;
            w_high_cnt_d = '0;
            w_stuck_d    = 1'b0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    w_per_cnt_d  = '0;
                    w_high_cnt_d = '0;
                    w_state_d    = ST_ARM;
                end
                ST_ARM: begin
                    // The period counter runs here only to time out a dead clock.
                    if (w_rise) begin
                        w_per_cnt_d  = c_CNT_ONE;
                        w_high_cnt_d = c_CNT_ONE;
                        w_state_d    = ST_MEAS;
                    end else if (r_per_cnt_q == c_CNT_MAX) begin
                        w_stuck_d    = 1'b1;
                        w_per_cnt_d  = '0;
                        w_high_cnt_d = '0;
                    end else begin
                        w_per_cnt_d  = w_per_inc;
                    end
                end
                ST_MEAS: begin
                    // The edge branch is tested first so a coincident
                    // timeout still reports the measurement.
                    if (w_rise) begin
                        w_period_d   = r_per_cnt_q;
                        w_high_d     = r_high_cnt_q;
                        w_match_d    = w_match;
                        w_valid_d    = 1'b1;
                        w_per_cnt_d  = c_CNT_ONE;
                        w_high_cnt_d = c_CNT_ONE;
                    end else if (r_per_cnt_q == c_CNT_MAX) begin
                        w_stuck_d    = 1'b1;
                        w_per_cnt_d  = '0;
                        w_high_cnt_d = '0;
                        w_state_d    = ST_ARM;
                    end else begin
                        w_per_cnt_d  = w_per_inc;
                        if (w_s1) begin
                            w_high_cnt_d = w_high_inc;
                        end
                    end
                end
                default: begin
                    w_state_d    = ST_IDLE;
                    w_per_cnt_d  = '0;
                    w_high_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q    <= ST_IDLE;
            r_per_cnt_q  <= '0;
            r_high_cnt_q <= '0;
            r_period_q   <= '0;
            r_high_q     <= '0;
            r_valid_q    <= 1'b0;
            r_match_q    <= 1'b0;
            r_stuck_q    <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_per_cnt_q  <= w_per_cnt_d;
            r_high_cnt_q <= w_high_cnt_d;
            r_period_q   <= w_period_d;
            r_high_q     <= w_high_d;
            r_valid_q    <= w_valid_d;
            r_match_q    <= w_match_d;
            r_stuck_q    <= w_stuck_d;
        end
    end

    assign o_period = r_period_q;
    assign o_high   = r_high_q;
    assign o_valid  = r_valid_q;
    assign o_match  = r_match_q;
    assign o_stuck  = r_stuck_q;

endmodule : clk_ratio_mon
`default_nettype wire
